// File: rtl/constraint_sampler_pkg.sv
// Shared types and constants for the rejection-sampling candidate generator:
// FSM states, variable layout inside the packed vector, and LFSR constants.
package constraint_sampler_pkg;

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_CHECK, S_HOLD, S_FAIL} state_t;

  // var_0 sits in the LSBs; widths sum to 185
  localparam int NUM_VARS = 10;
  localparam int VAR_WIDTH  [NUM_VARS] = '{16, 22, 4, 28, 19, 18, 19, 14, 16, 29};
  localparam int VAR_OFFSET [NUM_VARS] = '{0, 16, 38, 42, 70, 89, 107, 126, 140, 156};

  // Per-lane whitening so lanes seeded from one value diverge; all non-zero
  localparam int MAX_LANES = 4;
  localparam logic [63:0] LANE_K [MAX_LANES] = '{
    64'h9E37_79B9_7F4A_7C15, 64'hBF58_476D_1CE4_E5B9,
    64'h94D0_49BB_1331_11EB, 64'hD6E8_FEB8_6659_FD93};

  // Right-shift Galois mask for x^64 + x^63 + x^61 + x^60 + 1
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/sampler_lfsr.sv
// One Galois LFSR lane. A zero load is replaced by K so the lane never locks up.
module sampler_lfsr #(
  parameter int            W       = 64,
  parameter logic [W-1:0]  TAPS    = '1,
  parameter logic [W-1:0]  K       = '1,
  parameter logic [W-1:0]  RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] nxt
);
  logic [W-1:0] q;

  assign nxt = {1'b0, q[W-1:1]} ^ (q[0] ? TAPS : '0);

  always_ff @(posedge clk) begin
    if (rst)       q <= (RST_VAL == '0) ? K : RST_VAL;
    else if (load) q <= (load_val == '0) ? K : load_val;
    else if (step) q <= nxt;
  end
endmodule

// File: rtl/constraint_sample_gen.sv
// Rejection sampler: drives LFSR candidates to a combinational checker and
// streams out only those it flags as satisfying.
module constraint_sample_gen
  import constraint_sampler_pkg::*;
#(
  parameter int               VEC_W     = 185,
  parameter int               LFSR_W    = 64,
  parameter int               MAX_TRIES = 1024,
  parameter logic [LFSR_W-1:0] SEED     = 64'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_samples,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic [VEC_W-1:0]  cand_o,
  input  logic              sat_i,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [VEC_W-1:0]  sample_data,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [15:0]       tries
);
  localparam int          NUM_LANES = (VEC_W + LFSR_W - 1) / LFSR_W;
  localparam logic [31:0] MAX_T     = MAX_TRIES;

  state_t      state;
  logic [15:0] remaining;
  logic [15:0] tries_inc;
  logic        lane_load, lane_step;
  logic [NUM_LANES-1:0][LFSR_W-1:0] lane_nxt;
  logic [NUM_LANES*LFSR_W-1:0]      lane_cat;

  assign lane_load = (state == S_IDLE) && seed_load;
  assign lane_step = (state == S_GEN);
  assign lane_cat  = lane_nxt;
  assign tries_inc = (tries == 16'hFFFF) ? tries : tries + 16'd1;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    sampler_lfsr #(
      .W(LFSR_W), .TAPS(LFSR_TAPS[LFSR_W-1:0]), .K(LANE_K[k][LFSR_W-1:0]),
      .RST_VAL(SEED ^ LANE_K[k][LFSR_W-1:0])
    ) u_lfsr (
      .clk(clk), .rst(rst), .load(lane_load), .step(lane_step),
      .load_val(seed ^ LANE_K[k][LFSR_W-1:0]), .nxt(lane_nxt[k])
    );
  end

  if (NUM_LANES * LFSR_W > VEC_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^lane_cat[NUM_LANES*LFSR_W-1:VEC_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cand_o       <= '0;
      sample_data  <= '0;
      tries        <= '0;
      remaining    <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_FAIL: if (start) begin
          remaining <= num_samples;
          fail      <= 1'b0;
          tries     <= '0;
          if (num_samples == 16'd0) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            busy  <= 1'b1;
            state <= S_GEN;
          end
        end
        S_GEN: begin
          cand_o <= lane_cat[VEC_W-1:0];
          tries  <= tries_inc;
          state  <= S_CHECK;
        end
        S_CHECK: begin
          if (sat_i) begin
            sample_valid <= 1'b1;
            sample_data  <= cand_o;
            state        <= S_HOLD;
          end else if ({16'd0, tries} == MAX_T) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FAIL;
          end else begin
            state <= S_GEN;
          end
        end
        S_HOLD: if (sample_ready) begin
          sample_valid <= 1'b0;
          remaining    <= remaining - 16'd1;
          tries        <= '0;
          if (remaining == 16'd1) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_GEN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_constraint_sample_gen.sv
// Directed bench: stub checker accepts cand[3:0]==4'hA; a second instance with
// MAX_TRIES=8 covers exhaustion and recovery.
module tb_constraint_sample_gen;
  localparam int VW = 185;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0, seed_load = 1'b0, sample_ready = 1'b1;
  logic [15:0]   num_samples = '0;
  logic [63:0]   seed = '0;
  logic [1:0]    sat_mode = '0;
  logic [VW-1:0] cand_o, sample_data;
  logic          sat_i, sample_valid, busy, done, fail;
  logic [15:0]   tries;

  assign sat_i = (sat_mode == 2'd1) ? 1'b1 : (sat_mode == 2'd2) ? 1'b0 : (cand_o[3:0] == 4'hA);

  constraint_sample_gen u_dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .seed_load(seed_load), .seed(seed), .cand_o(cand_o), .sat_i(sat_i),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .busy(busy), .done(done), .fail(fail), .tries(tries));

  logic          start8 = 1'b0, seed_load8 = 1'b0, ready8 = 1'b1, sat8 = 1'b0;
  logic [15:0]   num8 = '0;
  logic [VW-1:0] cand8, data8;
  logic          valid8, busy8, done8, fail8;
  logic [15:0]   tries8;

  constraint_sample_gen #(.MAX_TRIES(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .num_samples(num8),
    .seed_load(seed_load8), .seed(seed), .cand_o(cand8), .sat_i(sat8),
    .sample_valid(valid8), .sample_ready(ready8), .sample_data(data8),
    .busy(busy8), .done(done8), .fail(fail8), .tries(tries8));

  int n_cmp = 0, n_bad = 0;
  int hs, dn, bz, dcyc, nib_bad;
  logic [VW-1:0] got[$];
  logic [VW-1:0] q1[$];

  // Start a batch (optionally with a same-cycle seed_load) and collect handshakes
  // until done; poke_at >= 0 re-issues start mid-batch with num_samples=5.
  task automatic run_batch(input int n, input bit with_seed, input logic [63:0] s, input int poke_at);
    got.delete(); hs = 0; dn = 0; bz = 0; dcyc = -1; nib_bad = 0;
    @(negedge clk);
    start = 1'b1; num_samples = n[15:0];
    if (with_seed) begin seed_load = 1'b1; seed = s; end
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      start = 1'b0; seed_load = 1'b0;
      if (c == poke_at) begin start = 1'b1; num_samples = 16'd5; end
      if (busy) bz++;
      if (sample_valid && sample_ready) begin
        hs++; got.push_back(sample_data);
        if (sample_data[3:0] != 4'hA) nib_bad++;
      end
      if (done) begin dn++; dcyc = c; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cand_o !== '0 || sample_data !== '0) begin
      n_bad++; $display("FAIL reset_data cand=%h data=%h want 0", cand_o, sample_data);
    end
    n_cmp++;
    if ({sample_valid, busy, done, fail, tries} !== '0) begin
      n_bad++; $display("FAIL reset_flags valid=%b busy=%b done=%b fail=%b tries=%0d want all 0",
                        sample_valid, busy, done, fail, tries);
    end
    rst = 1'b0;
  endtask

  task automatic test_batch3;
    sat_mode = 2'd0; sample_ready = 1'b1;
    run_batch(3, 1'b0, '0, -1);
    n_cmp++; if (hs !== 3) begin n_bad++; $display("FAIL batch3_handshakes got %0d want 3", hs); end
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL batch3_done got %0d want 1", dn); end
    n_cmp++; if (nib_bad !== 0) begin n_bad++; $display("FAIL batch3_sat_nibble bad=%0d want 0", nib_bad); end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sample_valid !== 1'b0) begin
      n_bad++; $display("FAIL batch3_after busy=%b done=%b valid=%b want 0 0 0", busy, done, sample_valid);
    end
  endtask

  task automatic test_seed;
    int diff;
    sat_mode = 2'd0; sample_ready = 1'b1;
    @(negedge clk); seed = 64'h1234_5678_9ABC_DEF0; seed_load = 1'b1;
    @(negedge clk); seed_load = 1'b0;
    run_batch(3, 1'b0, '0, -1);
    q1 = got;
    // same seed, this time loaded in the same cycle as start
    run_batch(3, 1'b1, 64'h1234_5678_9ABC_DEF0, -1);
    diff = 0;
    if (got.size() != 3 || q1.size() != 3) diff = 99;
    else for (int i = 0; i < 3; i++) if (got[i] !== q1[i]) diff++;
    n_cmp++; if (diff !== 0) begin n_bad++; $display("FAIL seed_repeat differing=%0d want 0", diff); end
    run_batch(4, 1'b1, 64'h0, -1);
    n_cmp++;
    if (got.size() != 4 || (got[0] === got[1] && got[1] === got[2] && got[2] === got[3])) begin
      n_bad++; $display("FAIL seed_zero_nonconst samples=%0d want 4 distinct-ish", got.size());
    end
  endtask

  task automatic test_stall;
    logic [VW-1:0] d0;
    logic [15:0]   t0;
    int bad, waited;
    sat_mode = 2'd0; sample_ready = 1'b0;
    @(negedge clk); start = 1'b1; num_samples = 16'd1;
    waited = 0;
    do begin @(negedge clk); start = 1'b0; waited++; end while (!sample_valid && waited < 4000);
    n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid_timeout got %b want 1", sample_valid); end
    d0 = sample_data; t0 = tries; bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!sample_valid || sample_data !== d0 || cand_o !== d0 || tries !== t0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL stall_stable bad_cycles=%0d want 0", bad); end
    n_cmp++; if (d0[3:0] !== 4'hA) begin n_bad++; $display("FAIL stall_nibble got %h want a", d0[3:0]); end
    sample_ready = 1'b1; hs = 0; dn = 0;
    for (int c = 0; c < 10; c++) begin
      if (sample_valid && sample_ready) hs++;
      if (done) begin dn++; break; end
      @(negedge clk);
    end
    n_cmp++; if (hs !== 1 || dn !== 1) begin n_bad++; $display("FAIL stall_release hs=%0d done=%0d want 1 1", hs, dn); end
  endtask

  task automatic test_fail;
    int cyc, h8, d8;
    sat8 = 1'b0;
    @(negedge clk); start8 = 1'b1; num8 = 16'd1;
    cyc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); start8 = 1'b0; cyc++;
      if (fail8) break;
    end
    n_cmp++; if (cyc !== 17 || fail8 !== 1'b1) begin n_bad++; $display("FAIL fail_latency cyc=%0d fail=%b want 17 1", cyc, fail8); end
    n_cmp++; if (tries8 !== 16'd8) begin n_bad++; $display("FAIL fail_tries got %0d want 8", tries8); end
    n_cmp++; if (busy8 !== 1'b0 || valid8 !== 1'b0) begin n_bad++; $display("FAIL fail_flags busy=%b valid=%b want 0 0", busy8, valid8); end
    sat8 = 1'b1; start8 = 1'b1; num8 = 16'd1;
    @(negedge clk); start8 = 1'b0;
    n_cmp++; if (fail8 !== 1'b0 || busy8 !== 1'b1) begin n_bad++; $display("FAIL fail_clear fail=%b busy=%b want 0 1", fail8, busy8); end
    h8 = 0; d8 = 0;
    for (int c = 0; c < 20; c++) begin
      if (valid8 && ready8) h8++;
      if (done8) begin d8++; break; end
      @(negedge clk);
    end
    n_cmp++; if (h8 !== 1 || d8 !== 1) begin n_bad++; $display("FAIL fail_recover hs=%0d done=%0d want 1 1", h8, d8); end
    sat8 = 1'b0;
  endtask

  task automatic test_zero_and_busy;
    sat_mode = 2'd0; sample_ready = 1'b1;
    run_batch(0, 1'b0, '0, -1);
    n_cmp++; if (dn !== 1 || dcyc !== 0) begin n_bad++; $display("FAIL zero_done done=%0d at=%0d want 1 0", dn, dcyc); end
    n_cmp++; if (hs !== 0 || bz !== 0) begin n_bad++; $display("FAIL zero_quiet hs=%0d busy_cycles=%0d want 0 0", hs, bz); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_pulse done=%b want 0", done); end
    run_batch(2, 1'b0, '0, 3);
    n_cmp++; if (hs !== 2 || dn !== 1) begin n_bad++; $display("FAIL busy_start_ignored hs=%0d done=%0d want 2 1", hs, dn); end
  endtask

  task automatic test_rst_hold;
    int h1;
    bit ok;
    sat_mode = 2'd0; sample_ready = 1'b1; hs = 0; h1 = 0; ok = 1'b0;
    @(negedge clk); start = 1'b1; num_samples = 16'd4;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk); start = 1'b0;
      if (hs == 1 && sample_valid && c > h1) begin ok = 1'b1; break; end
      if (sample_valid && sample_ready) begin hs++; h1 = c; sample_ready = 1'b0; end
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_reach_hold got %b want 1", ok); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sample_valid !== 1'b0 || busy !== 1'b0 || tries !== 16'd0 || cand_o !== '0) begin
      n_bad++; $display("FAIL rst_in_hold valid=%b busy=%b tries=%0d want 0 0 0", sample_valid, busy, tries);
    end
    rst = 1'b0; sample_ready = 1'b1;
    run_batch(2, 1'b0, '0, -1);
    n_cmp++; if (hs !== 2 || dn !== 1) begin n_bad++; $display("FAIL rst_next_batch hs=%0d done=%0d want 2 1", hs, dn); end
  endtask

  initial begin
    test_reset();
    test_batch3();
    test_seed();
    test_stall();
    test_fail();
    test_zero_and_busy();
    test_rst_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
